// File: rtl/net2_link_pkg.sv
// Shared types and helpers for the net2 serial link receiver.
package net2_link_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_ERR_W = 8;

`ifdef NET2_LINK_RX_PARITY_EN
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_PARITY} rx_state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT} rx_state_t;
`endif

  // Even-parity bit for a word zero-extended to 64 bits.
  function automatic logic even_parity(input logic [63:0] w);
    return ^w;
  endfunction

endpackage

// File: rtl/net2_fifo2.sv
// Two-entry FIFO with the head word always held in mem0.
module net2_fifo2 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enq,
  input  logic [WIDTH-1:0] din,
  input  logic             deq,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem0, mem1, mem0_nxt, mem1_nxt;
  logic [1:0]       cnt, cnt_nxt;
  logic             do_enq, do_deq;

  // A pop on a full buffer frees a slot for a same-cycle push.
  always_comb begin
    do_deq   = deq & ~empty;
    do_enq   = enq & (~full | do_deq);
    mem0_nxt = mem0;
    mem1_nxt = mem1;
    cnt_nxt  = cnt;
    case ({do_enq, do_deq})
      2'b10: begin
        if (cnt == 2'd0) mem0_nxt = din;
        else             mem1_nxt = din;
        cnt_nxt = cnt + 2'd1;
      end
      2'b01: begin
        mem0_nxt = mem1;
        cnt_nxt  = cnt - 2'd1;
      end
      2'b11: begin
        if (cnt == 2'd1) begin
          mem0_nxt = din;
        end else begin
          mem0_nxt = mem1;
          mem1_nxt = din;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem0  <= '0;
      mem1  <= '0;
      cnt   <= 2'd0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      mem0  <= mem0_nxt;
      mem1  <= mem1_nxt;
      cnt   <= cnt_nxt;
      empty <= (cnt_nxt == 2'd0);
      full  <= (cnt_nxt == 2'd2);
    end
  end

  assign dout = mem0;

endmodule

// File: rtl/net2_link_rx.sv
// Serial link receiver: deserialises framed MSB-first words into a 2-entry buffer.
// Optional trailing even-parity bit enabled by defining NET2_LINK_RX_PARITY_EN.
module net2_link_rx
  import net2_link_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned ERR_W = DEF_ERR_W
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             line_frame,
  input  logic             line_data,
  input  logic             deq_EN,
  output logic             deq_RDY,
  output logic [WIDTH-1:0] first,
  input  logic             clear_EN,
  output logic [ERR_W-1:0] err_count,
  output logic             overflow
);

  localparam int unsigned     CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  rx_state_t        state, state_nxt;
  logic [WIDTH-1:0] shreg, word_c;
  logic [CNT_W-1:0] bit_cnt;
  logic             load_c, shift_c, word_vld_c, err_ev_c, drop_c;
  logic             fifo_full, fifo_empty;
  logic             last_bit;

  assign last_bit = (bit_cnt == LAST_CNT);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (line_frame) state_nxt = ST_SHIFT;
      ST_SHIFT: begin
        if (!line_frame) begin
          state_nxt = ST_IDLE;
        end else if (last_bit) begin
`ifdef NET2_LINK_RX_PARITY_EN
          state_nxt = ST_PARITY;
`else
          state_nxt = ST_IDLE;
`endif
        end
      end
`ifdef NET2_LINK_RX_PARITY_EN
      ST_PARITY: state_nxt = ST_IDLE;
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Per-cycle strobes; a completed word is pushed on the edge that samples its last bit.
  always_comb begin
    load_c     = 1'b0;
    shift_c    = 1'b0;
    word_vld_c = 1'b0;
    err_ev_c   = 1'b0;
    word_c     = {shreg[WIDTH-2:0], line_data};
    case (state)
      ST_IDLE: load_c = line_frame;
      ST_SHIFT: begin
        if (line_frame) begin
          shift_c = 1'b1;
`ifndef NET2_LINK_RX_PARITY_EN
          word_vld_c = last_bit;
`endif
        end else begin
          err_ev_c = 1'b1;
        end
      end
`ifdef NET2_LINK_RX_PARITY_EN
      ST_PARITY: begin
        word_c = shreg;
        if (line_frame && (line_data == even_parity(64'(shreg)))) word_vld_c = 1'b1;
        else                                                      err_ev_c   = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign drop_c = word_vld_c & fifo_full & ~deq_EN;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (load_c) begin
      shreg   <= WIDTH'(line_data);
      bit_cnt <= CNT_W'(1);
    end else if (shift_c) begin
      shreg   <= word_c;
      bit_cnt <= bit_cnt + CNT_W'(1);
    end
  end

  // A new event takes priority over a coincident clear.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      err_count <= '0;
      overflow  <= 1'b0;
    end else begin
      if (err_ev_c) begin
        if (clear_EN)              err_count <= ERR_W'(1);
        else if (err_count != '1)  err_count <= err_count + ERR_W'(1);
      end else if (clear_EN) begin
        err_count <= '0;
      end
      if (drop_c)        overflow <= 1'b1;
      else if (clear_EN) overflow <= 1'b0;
    end
  end

  net2_fifo2 #(.WIDTH(WIDTH)) u_fifo (
    .clk   (CLK),
    .rst_n (RST_N),
    .enq   (word_vld_c),
    .din   (word_c),
    .deq   (deq_EN),
    .dout  (first),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign deq_RDY = ~fifo_empty;

endmodule

// File: tb/tb_net2_link_rx.sv
// Directed self-checking bench for net2_link_rx (WIDTH=32, ERR_W=8).
module tb_net2_link_rx;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        line_frame, line_data, deq_EN, clear_EN;
  logic        deq_RDY, overflow;
  logic [31:0] first;
  logic [7:0]  err_count;

  int checks   = 0;
  int failures = 0;

  localparam logic [1:0] OP_NONE = 2'd0, OP_DEQ = 2'd1, OP_CLR = 2'd2;

  net2_link_rx #(.WIDTH(32), .ERR_W(8)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .line_frame (line_frame),
    .line_data  (line_data),
    .deq_EN     (deq_EN),
    .deq_RDY    (deq_RDY),
    .first      (first),
    .clear_EN   (clear_EN),
    .err_count  (err_count),
    .overflow   (overflow)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Frame high for n bits of w, MSB first; frame is left high.
  task automatic send_bits(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      line_frame = 1'b1;
      line_data  = w[31-i];
      tick();
    end
  endtask

  // Full word (plus parity bit when built with it); op strobes on the final sampled bit.
  task automatic send_word(input logic [31:0] w, input logic [1:0] op, input logic par_flip);
    int nb;
`ifdef NET2_LINK_RX_PARITY_EN
    nb = 33;
`else
    nb = 32;
`endif
    for (int i = 0; i < nb; i++) begin
      line_frame = 1'b1;
      line_data  = (i < 32) ? w[31-i] : ((^w) ^ par_flip);
      deq_EN     = (i == nb - 1) && (op == OP_DEQ);
      clear_EN   = (i == nb - 1) && (op == OP_CLR);
      tick();
    end
    line_frame = 1'b0;
    line_data  = 1'b0;
    deq_EN     = 1'b0;
    clear_EN   = 1'b0;
  endtask

  task automatic pop();
    deq_EN = 1'b1;
    tick();
    deq_EN = 1'b0;
  endtask

  task automatic clear();
    clear_EN = 1'b1;
    tick();
    clear_EN = 1'b0;
  endtask

  initial begin
    RST_N = 1'b0; line_frame = 1'b0; line_data = 1'b0; deq_EN = 1'b0; clear_EN = 1'b0;
    repeat (2) tick();
    check("rst_rdy", 64'(deq_RDY), 64'd0);
    check("rst_first", 64'(first), 64'd0);
    check("rst_err", 64'(err_count), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    RST_N = 1'b1;
    tick();

    // Single word, visible one cycle after the last bit
    send_word(32'hDEADBEEF, OP_NONE, 1'b0);
    check("single_rdy", 64'(deq_RDY), 64'd1);
    check("single_first", 64'(first), 64'hDEADBEEF);
    pop();
    check("single_pop_rdy", 64'(deq_RDY), 64'd0);

    // Back-to-back with zero gap
    send_word(32'h00000001, OP_NONE, 1'b0);
    send_word(32'h80000000, OP_NONE, 1'b0);
    check("b2b_rdy", 64'(deq_RDY), 64'd1);
    check("b2b_first0", 64'(first), 64'h00000001);
    check("b2b_err", 64'(err_count), 64'd0);
    pop();
    check("b2b_rdy1", 64'(deq_RDY), 64'd1);
    check("b2b_first1", 64'(first), 64'h80000000);
    pop();
    check("b2b_empty", 64'(deq_RDY), 64'd0);

    // Abort after 10 bits, then a good word
    send_bits(32'hFFFFFFFF, 10);
    line_frame = 1'b0;
    tick();
    check("abort_err", 64'(err_count), 64'd1);
    check("abort_rdy", 64'(deq_RDY), 64'd0);
    send_word(32'h12345678, OP_NONE, 1'b0);
    check("abort_next", 64'(first), 64'h12345678);
    pop();

    // Overflow: third word dropped
    send_word(32'hAAAA0001, OP_NONE, 1'b0);
    send_word(32'hAAAA0002, OP_NONE, 1'b0);
    send_word(32'hAAAA0003, OP_NONE, 1'b0);
    check("ovf_flag", 64'(overflow), 64'd1);
    check("ovf_err", 64'(err_count), 64'd1);
    check("ovf_head", 64'(first), 64'hAAAA0001);
    pop();
    check("ovf_second", 64'(first), 64'hAAAA0002);
    pop();
    check("ovf_drained", 64'(deq_RDY), 64'd0);
    clear();
    check("clr_ovf", 64'(overflow), 64'd0);
    check("clr_err", 64'(err_count), 64'd0);

    // Full buffer with pop on completion: third word accepted
    send_word(32'hBBBB0001, OP_NONE, 1'b0);
    send_word(32'hBBBB0002, OP_NONE, 1'b0);
    send_word(32'hBBBB0003, OP_DEQ, 1'b0);
    check("popcmp_ovf", 64'(overflow), 64'd0);
    check("popcmp_head", 64'(first), 64'hBBBB0002);
    pop();
    check("popcmp_third", 64'(first), 64'hBBBB0003);
    pop();
    check("popcmp_empty", 64'(deq_RDY), 64'd0);

    // Reset mid-word with non-zero state
    send_word(32'h0000FFFF, OP_NONE, 1'b0);
    send_bits(32'h0, 3);
    line_frame = 1'b0;
    tick();
    send_bits(32'hA5A5A5A5, 16);
    RST_N = 1'b0;
    #1;
    check("midrst_rdy", 64'(deq_RDY), 64'd0);
    check("midrst_first", 64'(first), 64'd0);
    check("midrst_err", 64'(err_count), 64'd0);
    check("midrst_ovf", 64'(overflow), 64'd0);
    line_frame = 1'b0;
    tick();
    RST_N = 1'b1;
    tick();
    send_word(32'hCAFEF00D, OP_NONE, 1'b0);
    check("postrst_word", 64'(first), 64'hCAFEF00D);
    check("postrst_err", 64'(err_count), 64'd0);
    pop();

    // Error counter saturation and clear
    for (int i = 0; i < 255; i++) begin
      line_frame = 1'b1; line_data = 1'b1;
      tick();
      line_frame = 1'b0;
      tick();
    end
    check("sat_ff", 64'(err_count), 64'hFF);
    line_frame = 1'b1;
    tick();
    line_frame = 1'b0;
    tick();
    check("sat_hold", 64'(err_count), 64'hFF);
    clear();
    check("sat_clear", 64'(err_count), 64'd0);

    // Clear coinciding with an abort / an overflow
    send_bits(32'h0, 3);
    line_frame = 1'b0;
    clear_EN   = 1'b1;
    tick();
    clear_EN   = 1'b0;
    check("clr_abort_err", 64'(err_count), 64'd1);
    send_word(32'hCC000001, OP_NONE, 1'b0);
    send_word(32'hCC000002, OP_NONE, 1'b0);
    send_word(32'hCC000003, OP_CLR, 1'b0);
    check("clr_ovf_set", 64'(overflow), 64'd1);
    check("clr_ovf_err", 64'(err_count), 64'd0);
    pop();
    pop();
    check("clr_ovf_drained", 64'(deq_RDY), 64'd0);

`ifdef NET2_LINK_RX_PARITY_EN
    clear();
    send_word(32'h00000003, OP_NONE, 1'b1);
    check("par_bad_err", 64'(err_count), 64'd1);
    check("par_bad_rdy", 64'(deq_RDY), 64'd0);
    send_word(32'h00000003, OP_NONE, 1'b0);
    check("par_good_rdy", 64'(deq_RDY), 64'd1);
    check("par_good_word", 64'(first), 64'h00000003);
    check("par_good_err", 64'(err_count), 64'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
